// File: rtl/crc_pkg.sv
// Shared types and helpers for the serial CRC engine: FSM state encoding,
// the CAN CRC-15 generator and the single-bit CRC update function.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SHIFT
  } crc_state_t;

  localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;

  // One serial CRC step on a register of 'width' bits (2..32), carried in 32 bits.
  function automatic logic [31:0] crc_next(
    input logic [31:0] crc,
    input logic        din,
    input logic [31:0] poly,
    input int unsigned width
  );
    logic [31:0] mask;
    logic [31:0] msb_vec;
    logic        fb;
    mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    msb_vec = crc >> (width - 1);
    fb      = din ^ msb_vec[0];
    return ((crc << 1) ^ (fb ? poly : 32'd0)) & mask;
  endfunction

endpackage

// File: rtl/crc_lfsr.sv
// WIDTH-bit CRC register: async reset, synchronous clear to INIT, CRC update
// or plain shift (for transmit), plus the zero detect used as crc_ok.
module crc_lfsr
  import crc_pkg::*;
#(
  parameter int               WIDTH = 15,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(CAN_CRC15_POLY),
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             update_en,
  input  logic             shift_en,
  input  logic             bitin,
  output logic [WIDTH-1:0] crc_reg,
  output logic             crc_ok
);

  // Shift-out has priority over update; the top never asserts both.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc_reg <= INIT;
    end else if (clear) begin
      crc_reg <= INIT;
    end else if (shift_en) begin
      crc_reg <= {crc_reg[WIDTH-2:0], 1'b0};
    end else if (update_en) begin
      crc_reg <= WIDTH'(crc_next(32'(crc_reg), bitin, 32'(POLY), WIDTH));
    end
  end

  assign crc_ok = (crc_reg == '0);

endmodule

// File: rtl/crc_stream_engine.sv
// Serial CRC engine for both CAN directions: checks receive bits or generates
// and shifts out the transmit CRC. Shift-out exists only with CRC_SHIFTOUT_EN.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int               WIDTH = 15,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(CAN_CRC15_POLY),
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             activ,
  input  logic             bitin,
  input  logic             start_tx,
  output logic [WIDTH-1:0] crc_reg,
  output logic             crc_ok,
  output logic             crc_bit,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  crc_state_t state;
  crc_state_t state_next;
  logic       activ_q;
  logic       step;
  logic       start_go;
  logic       update_en;
  logic       shift_en;
  logic       last_shift;

  // A strobe held high for many cycles still yields a single step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) activ_q <= 1'b0;
    else       activ_q <= activ;
  end

  assign step = activ & ~activ_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (step) state_next = ACCUM;
        ACCUM:   if (start_go) state_next = SHIFT;
        SHIFT:   if (last_shift) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // A step coinciding with start_tx is swallowed rather than accumulated.
  always_comb begin
    update_en = 1'b0;
    shift_en  = 1'b0;
    if (!clear && step) begin
      if (state == IDLE || (state == ACCUM && !start_go)) update_en = 1'b1;
      if (state == SHIFT) shift_en = 1'b1;
    end
  end

`ifdef CRC_SHIFTOUT_EN
  logic [CNT_W-1:0] bit_cnt;

  assign start_go   = (state == ACCUM) && start_tx;
  assign last_shift = shift_en && (bit_cnt == CNT_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
    end else if (clear) begin
      bit_cnt <= '0;
    end else if (start_go) begin
      bit_cnt <= CNT_W'(WIDTH);
    end else if (shift_en && bit_cnt != '0) begin
      bit_cnt <= bit_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tx_done <= 1'b0;
    else       tx_done <= last_shift;
  end

  assign tx_busy = (state == SHIFT);
  assign crc_bit = crc_reg[WIDTH-1];
`else
  logic unused_start_tx;

  assign unused_start_tx = start_tx;
  assign start_go        = 1'b0;
  assign last_shift      = 1'b0;
  assign tx_done         = 1'b0;
  assign tx_busy         = 1'b0;
  assign crc_bit         = 1'b0;
`endif

  crc_lfsr #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .INIT  (INIT)
  ) u_lfsr (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .update_en (update_en),
    .shift_en  (shift_en),
    .bitin     (bitin),
    .crc_reg   (crc_reg),
    .crc_ok    (crc_ok)
  );

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine with default CAN CRC-15 parameters;
// shift-out vectors run only when CRC_SHIFTOUT_EN is defined.
module tb_crc_stream_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        activ = 1'b0;
  logic        bitin = 1'b0;
  logic        start_tx = 1'b0;
  logic [14:0] crc_reg;
  logic        crc_ok;
  logic        crc_bit;
  logic        tx_busy;
  logic        tx_done;

  int checks = 0;
  int errors = 0;

  logic [14:0] poly_bits = 15'h4599;

  crc_stream_engine dut (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .activ    (activ),
    .bitin    (bitin),
    .start_tx (start_tx),
    .crc_reg  (crc_reg),
    .crc_ok   (crc_ok),
    .crc_bit  (crc_bit),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One bit strobe: activ high for one cycle, then low for one cycle.
  task automatic apply_stimulus(input logic b);
    @(negedge clock);
    bitin = b;
    activ = 1'b1;
    @(negedge clock);
    activ = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start_tx = 1'b1;
    @(negedge clock);
    start_tx = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state
    check_output("rst_crc", 32'(crc_reg), 32'h0000);
    check_output("rst_ok", 32'(crc_ok), 32'd1);
    check_output("rst_busy", 32'(tx_busy), 32'd0);
    check_output("rst_done", 32'(tx_done), 32'd0);
    check_output("rst_bit", 32'(crc_bit), 32'd0);

    // Strobe held high for 5 cycles applies one update only
    @(negedge clock);
    bitin = 1'b1;
    activ = 1'b1;
    repeat (5) @(negedge clock);
    activ = 1'b0;
    @(negedge clock);
    check_output("hold_crc", 32'(crc_reg), 32'h4599);
    check_output("hold_ok", 32'(crc_ok), 32'd0);

    // "1" followed by its CRC leaves zero
    do_reset();
    apply_stimulus(1'b1);
    for (int i = 14; i >= 0; i--) apply_stimulus(poly_bits[i]);
    check_output("good_crc", 32'(crc_reg), 32'h0000);
    check_output("good_ok", 32'(crc_ok), 32'd1);

    // Last bit flipped: differs by one POLY
    do_reset();
    apply_stimulus(1'b1);
    for (int i = 14; i >= 0; i--) apply_stimulus(i == 0 ? ~poly_bits[i] : poly_bits[i]);
    check_output("flip0_crc", 32'(crc_reg), 32'h4599);
    check_output("flip0_ok", 32'(crc_ok), 32'd0);

    // Second-to-last bit flipped
    do_reset();
    apply_stimulus(1'b1);
    for (int i = 14; i >= 0; i--) apply_stimulus(i == 1 ? ~poly_bits[i] : poly_bits[i]);
    check_output("flip1_crc", 32'(crc_reg), 32'h4EAB);
    check_output("flip1_ok", 32'(crc_ok), 32'd0);

    // clear together with a strobe mid-frame drops the bit
    do_reset();
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    @(negedge clock);
    clear = 1'b1;
    activ = 1'b1;
    bitin = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    activ = 1'b0;
    check_output("clear_crc", 32'(crc_reg), 32'h0000);
    check_output("clear_ok", 32'(crc_ok), 32'd1);
    apply_stimulus(1'b1);
    check_output("after_clear_crc", 32'(crc_reg), 32'h4599);

`ifdef CRC_SHIFTOUT_EN
    // start_tx in IDLE is ignored
    do_reset();
    pulse_start();
    check_output("idle_start_busy", 32'(tx_busy), 32'd0);

    // Full shift-out of the CRC of "1"
    apply_stimulus(1'b1);
    pulse_start();
    check_output("sh_busy", 32'(tx_busy), 32'd1);
    check_output("sh_crc0", 32'(crc_reg), 32'h4599);
    for (int i = 14; i >= 0; i--) begin
      check_output($sformatf("sh_bit%0d", i), 32'(crc_bit), 32'(poly_bits[i]));
      apply_stimulus(1'b1);
      check_output($sformatf("sh_done%0d", i), 32'(tx_done), (i == 0) ? 32'd1 : 32'd0);
    end
    check_output("sh_crc_end", 32'(crc_reg), 32'h0000);
    check_output("sh_ok_end", 32'(crc_ok), 32'd1);
    check_output("sh_busy_end", 32'(tx_busy), 32'd0);
    @(negedge clock);
    check_output("sh_done_drop", 32'(tx_done), 32'd0);

    // start_tx coinciding with a strobe: that strobe is not shifted
    do_reset();
    apply_stimulus(1'b1);
    @(negedge clock);
    start_tx = 1'b1;
    activ = 1'b1;
    bitin = 1'b0;
    @(negedge clock);
    start_tx = 1'b0;
    activ = 1'b0;
    check_output("co_crc", 32'(crc_reg), 32'h4599);
    check_output("co_busy", 32'(tx_busy), 32'd1);

    // Reset after the 7th shift-out strobe aborts without tx_done
    do_reset();
    apply_stimulus(1'b1);
    pulse_start();
    repeat (7) apply_stimulus(1'b0);
    check_output("ab_busy_pre", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    #1;
    check_output("ab_crc", 32'(crc_reg), 32'h0000);
    check_output("ab_busy", 32'(tx_busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check_output("ab_done", 32'(tx_done), 32'd0);
    end
`else
    // Shift-out absent: start_tx ignored, outputs tied low
    do_reset();
    apply_stimulus(1'b1);
    pulse_start();
    check_output("nosh_busy", 32'(tx_busy), 32'd0);
    apply_stimulus(1'b0);
    check_output("nosh_crc", 32'(crc_reg), 32'h4EAB);
    check_output("nosh_done", 32'(tx_done), 32'd0);
    check_output("nosh_bit", 32'(crc_bit), 32'd0);

    // Asynchronous reset mid-frame
    reset = 1'b1;
    #1;
    check_output("async_rst_crc", 32'(crc_reg), 32'h0000);
    @(negedge clock);
    reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_stream_engine.md
# crc_stream_engine

Parametrised serial CRC engine for the CAN MAC datapath. It replaces the fixed 15-bit receive-only checker with one block that serves both directions. In check mode it accumulates destuffed receive bits and reports `crc_ok`. In generate mode it accumulates transmit bits and then shifts the CRC out MSB-first. It sits between the destuff/stuff units and the MAC FSM, and is clocked once per sampled bit via the `activ` strobe.

## Interface
Parameters:
- `WIDTH`, 15: CRC register width, 2..32.
- `POLY`, 15'h4599: generator polynomial with the x^WIDTH term omitted, WIDTH bits.
- `INIT`, 0: register value after reset and after `clear`, WIDTH bits.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous frame-start; loads `INIT`, forces IDLE.
- `activ`  in  1  bit strobe from the MAC FSM; each 0→1 transition consumes exactly one bit.
- `bitin`  in  1  serial data bit, sampled on the edge that detects the `activ` rise.
- `start_tx`  in  1  one-cycle request to begin shift-out (only with `CRC_SHIFTOUT_EN`).
- `crc_reg`  out  WIDTH  current register contents.
- `crc_ok`  out  1  high when `crc_reg == 0`.
- `crc_bit`  out  1  bit currently being transmitted (with `CRC_SHIFTOUT_EN`).
- `tx_busy`  out  1  high during the SHIFT state.
- `tx_done`  out  1  one-cycle pulse when the last CRC bit has been consumed.

## Operation
- Edge detection:
  - Register `activ_q` holds the previous `activ`.
  - `step = activ & ~activ_q`.
  - A strobe held high for N cycles produces exactly one step.
- Update rule, on a step in ACCUM:
  - `fb = bitin ^ crc_reg[WIDTH-1]`.
  - `crc_reg <= {crc_reg[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0)`.
  - All arithmetic is mod-2 within WIDTH bits; the MSB shifted out is discarded.
- FSM states:
  - IDLE: register holds its value; a step moves to ACCUM and applies that first bit on the same edge.
  - ACCUM: each step applies the update rule. `start_tx` moves to SHIFT with `bit_cnt <= WIDTH`.
  - SHIFT: on each step, `crc_reg <= {crc_reg[WIDTH-2:0],1'b0}` and `bit_cnt` decrements; `bitin` is ignored. When `bit_cnt` reaches 1 at a step, pulse `tx_done` and go to IDLE.
- `crc_bit = crc_reg[WIDTH-1]`, combinational; it is valid while `tx_busy` is high.
- `crc_ok` is combinational from `crc_reg`.
  - In check mode, a correct frame+CRC stream leaves the register at 0.
  - After a complete shift-out, the register is 0, so `crc_ok` is 1.
- Priority: `reset` > `clear` > `start_tx` > step. On `clear`+step in the same cycle, the bit is dropped.
- `start_tx` outside ACCUM is ignored.
- `bit_cnt` width is `$clog2(WIDTH+1)`; it never wraps.

## Timing
- Reset values:
  - `crc_reg = INIT`, state IDLE, `activ_q = 0`, `bit_cnt = 0`.
  - `tx_busy = 0`, `tx_done = 0`.
  - `crc_ok = (INIT == 0)`, `crc_bit = INIT[WIDTH-1]`.
- Latency: `crc_reg` reflects a bit one rising edge after `activ` is seen high.
- Minimum strobe spacing: `activ` low for ≥1 cycle between bits.
- `tx_done` is registered and high for exactly one cycle.
- `start_tx` and a step in the same cycle: go to SHIFT; that step is not shifted.
- Reset mid-SHIFT: the shift-out is aborted immediately; no `tx_done` is issued.

## Configuration
- `CRC_SHIFTOUT_EN` defined: the SHIFT state, `bit_cnt`, `start_tx`, `crc_bit`, `tx_busy` and `tx_done` logic are present.
- `CRC_SHIFTOUT_EN` undefined:
  - The FSM has only IDLE/ACCUM and `start_tx` is ignored.
  - `crc_bit`, `tx_busy` and `tx_done` are tied to 0.
  - The check path is unchanged.

## Structure
- Package `crc_pkg` contains:
  - the state enum {IDLE, ACCUM, SHIFT};
  - constant `CAN_CRC15_POLY = 15'h4599`;
  - a function `crc_next(reg, bit, poly)` implementing the update rule.
- Sub-module `crc_lfsr`: the WIDTH-bit register with async reset, `clear` load, update/shift select and the zero detect. The top level holds the edge detector, FSM and counter.

## Test plan
- Reset with default parameters → `crc_reg = 15'h0000`, `crc_ok = 1`, `tx_busy = 0`.
- Single `bitin = 1` strobe held high for 5 cycles → `crc_reg = 15'h4599` after one update only, `crc_ok = 0`.
- Stream "1", then bits of `15'h4599` MSB-first (100010110011001) → `crc_reg = 0`, `crc_ok = 1` after the 16th strobe. Flipping any bit gives `crc_ok = 0`.
- `CRC_SHIFTOUT_EN`: feed "1", assert `start_tx`, then 15 strobes → `crc_bit` sequence 100010110011001, `tx_done` pulse on the 15th, `crc_reg = 0`.
- `clear` and strobe in the same cycle mid-frame → `crc_reg = INIT`, state IDLE, bit not applied.
- `reset` asserted after the 7th shift-out strobe → immediate `crc_reg = INIT`, `tx_busy = 0`, no `tx_done`.
